bp_me_addr_to_cce_id_pipe: RTL
==============================

# bp_me_addr_to_cce_id_pipe

Registered, runtime-configurable successor to the combinational address-to-CCE-ID decode. Accepts a stream of physical addresses over a valid/ready handshake, resolves each to the owning CCE ID, and presents the result one cycle later with the address. Destination selection has three layers: a programmable region override table, a programmable DRAM striping granularity, and the fixed class decode (I/O, local tile, DRAM, streaming accelerator). Sits between LCE-side request injection and the coherence network.

## Interface
- paddr_width_p, 40, physical address width
- cce_id_width_p, 6, CCE ID width
- num_core_p, 4, tile CCE count (IDs 0..num_core_p-1)
- num_cce_p, 4, striped DRAM CCEs; power of two
- num_io_p, 1, I/O CCEs; base ID io_base_p
- io_base_p, 8, first I/O CCE ID
- sacc_base_p, 7, streaming-accelerator CCE ID
- num_region_p, 4, override table entries (1..8)
- dram_base_p, 40'h00_8000_0000, DRAM base
- coproc_base_p, 40'h10_0000_0000, first address above DRAM
- tile_lsb_p, 22, LSB of tile field in local addresses
- host_tile_p, 'h7F, tile field value meaning host device
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- v_i  in  1  request valid
- ready_o  out  1  request accepted when v_i & ready_o
- paddr_i  in  paddr_width_p  address
- v_o  out  1  result valid
- ready_i  in  1  consumer ready
- paddr_o  out  paddr_width_p  registered address
- cce_id_o  out  cce_id_width_p  destination CCE
- region_hit_o  out  1  result came from override table
- cfg_w_v_i  in  1  config write strobe
- cfg_addr_i  in  5  config register index
- cfg_data_i  in  64  write data
- cfg_data_o  out  64  readback of register at cfg_addr_i (combinational)

## Operation
- Config regs: addr 0 = stripe_shift[5:0] (reset 6, writes clamped to 6..30); addr 1+3k/2+3k/3+3k = region k base, mask, {en[8], id[cce_id_width_p-1:0]}; all region regs reset 0; unmapped reads return 0, writes ignored.
- Region k hits when en & ((paddr & mask) == (base & mask)); lowest k wins.
- Class decode, no hit, in order:
  - paddr[paddr_width_p-1:paddr_width_p-2] > 1, or (paddr < dram_base_p and tile field == host_tile_p): io_base_p + ((paddr >> 12) mod num_io_p).
  - paddr < dram_base_p: tile field, zero-extended/truncated to cce_id_width_p.
  - dram_base_p <= paddr < coproc_base_p: (paddr >> stripe_shift) mod num_cce_p.
  - otherwise: sacc_base_p.
- Decode reads config as of the accepting cycle; a write on the accepting cycle takes effect for later requests only.

## Timing
- Reset: v_o=0, paddr_o=0, cce_id_o=0, region_hit_o=0, config at reset values; ready_o=1 after reset.
- Latency 1: accepted at edge N, v_o high after edge N.
- ready_o = ~v_o | ready_i; full throughput with ready_i held high, no bubbles.
- v_o & ~ready_i: outputs held stable until consumed; no new accept.
- Simultaneous consume and accept: output replaced by new result the same edge.
- Reset mid-stream: in-flight result discarded, config reverts.

## Structure
- Shared package bp_me_pkg: config register index constants, bp_me_cce_region_s {en, id, base, mask}.
- Sub-module bp_me_cce_region_match: combinational priority match over the table, outputs hit and id.
- Pipeline register plus config file in top.

## Test plan
- Reset, paddr 40'h00_8000_0040 -> cce_id 1 (shift 6, 4 CCEs), region_hit 0, one cycle later.
- Write stripe_shift=12; paddr 40'h00_8000_3040 -> 3; same paddr issued on the write cycle -> 1.
- Region 0 base 40'h00_9000_0000 mask 40'hFF_F000_0000 id 5 en; 40'h00_9123_4000 -> 5, hit 1; also enable region 1 matching same address id 6 -> still 5.
- ready_i low 3 cycles with v_i high: outputs stable, ready_o low, one accepted per consume, no drop/duplicate across 100 back-to-back randoms against model.
- paddr 40'h80_0000_0000 -> 8; 40'h00_0080_0000 -> tile 2; 40'h10_0000_0000 -> 7.
- Assert reset_n_i with v_o high: v_o falls without clock, stripe_shift reads 6.

Source files
------------

// File: rtl/bp_me_pkg.sv
// Shared definitions for the address-to-CCE-ID pipe: config register map,
// region override entry layout and small config helpers.
package bp_me_pkg;

    localparam int bp_me_paddr_width_lp  = 40;
    localparam int bp_me_cce_id_width_lp = 6;
    localparam int cfg_addr_width_lp     = 5;
    localparam int cfg_data_width_lp     = 64;

    // Register map: 0 = stripe shift, then three registers per region entry.
    localparam logic [cfg_addr_width_lp-1:0] cfg_stripe_addr_lp = 5'd0;
    localparam int cfg_region_base_lp   = 1;
    localparam int cfg_region_stride_lp = 3;
    localparam int cfg_field_base_lp    = 0;
    localparam int cfg_field_mask_lp    = 1;
    localparam int cfg_field_ctrl_lp    = 2;
    localparam int cfg_ctrl_en_bit_lp   = 8;

    localparam logic [5:0] stripe_reset_lp = 6'd6;
    localparam logic [5:0] stripe_min_lp   = 6'd6;
    localparam logic [5:0] stripe_max_lp   = 6'd30;

    // Width of the tile field in local addresses (matches the host tile code).
    localparam int tile_width_lp = 7;

    typedef struct packed {
        logic                             en;
        logic [bp_me_cce_id_width_lp-1:0] id;
        logic [bp_me_paddr_width_lp-1:0]  base;
        logic [bp_me_paddr_width_lp-1:0]  mask;
    } bp_me_cce_region_s;

    function automatic logic [cfg_addr_width_lp-1:0] cfg_region_addr(input int k, input int field);
        return cfg_addr_width_lp'(cfg_region_base_lp + cfg_region_stride_lp * k + field);
    endfunction

    function automatic logic [5:0] clamp_stripe(input logic [cfg_data_width_lp-1:0] v);
        if (v < cfg_data_width_lp'(stripe_min_lp)) return stripe_min_lp;
        if (v > cfg_data_width_lp'(stripe_max_lp)) return stripe_max_lp;
        return v[5:0];
    endfunction

endpackage

// File: rtl/bp_me_addr_to_cce_id_pipe_if.sv
// Request/result stream of the address-to-CCE-ID pipe; signal names are
// from the pipe's point of view (slave = pipe, master = producer/consumer).
interface bp_me_addr_to_cce_id_pipe_if #(
    parameter int paddr_width_p  = 40,
    parameter int cce_id_width_p = 6
);
    // Handshake: a request transfers on an edge where v_i & ready_o; a result
    // transfers where v_o & ready_i. v_o and its payload stay stable until taken.
    logic                      v_i;
    logic                      ready_o;
    logic [paddr_width_p-1:0]  paddr_i;
    logic                      v_o;
    logic                      ready_i;
    logic [paddr_width_p-1:0]  paddr_o;
    logic [cce_id_width_p-1:0] cce_id_o;
    logic                      region_hit_o;

    modport slave (
        input  v_i, paddr_i, ready_i,
        output ready_o, v_o, paddr_o, cce_id_o, region_hit_o
    );

    modport master (
        output v_i, paddr_i, ready_i,
        input  ready_o, v_o, paddr_o, cce_id_o, region_hit_o
    );
endinterface

// File: rtl/bp_me_cce_region_match.sv
// Combinational priority match of an address against the region override
// table; the lowest-indexed enabled matching entry supplies the ID.
module bp_me_cce_region_match
    import bp_me_pkg::*;
#(
    parameter int num_region_p = 4
) (
    input  logic [bp_me_paddr_width_lp-1:0]                i_paddr,
    input  bp_me_cce_region_s [num_region_p-1:0]           i_regions,
    output logic                                           o_hit,
    output logic [bp_me_cce_id_width_lp-1:0]               o_id
);

    // Walk from the top so the lowest index is the last (winning) assignment.
    always_comb begin
        o_hit = 1'b0;
        o_id  = '0;
        for (int k = num_region_p - 1; k >= 0; k--) begin
            if (i_regions[k].en &&
                ((i_paddr & i_regions[k].mask) == (i_regions[k].base & i_regions[k].mask))) begin
                o_hit = 1'b1;
                o_id  = i_regions[k].id;
            end
        end
    end

endmodule

// File: rtl/bp_me_addr_to_cce_id_pipe.sv
// Registered, runtime-configurable physical address to CCE ID decode with a
// one-deep valid/ready output stage and a small config register file.
module bp_me_addr_to_cce_id_pipe
    import bp_me_pkg::*;
#(
    parameter int                       paddr_width_p  = bp_me_paddr_width_lp,
    parameter int                       cce_id_width_p = bp_me_cce_id_width_lp,
    parameter int                       num_core_p     = 4,
    parameter int                       num_cce_p      = 4,
    parameter int                       num_io_p       = 1,
    parameter int                       io_base_p      = 8,
    parameter int                       sacc_base_p    = 7,
    parameter int                       num_region_p   = 4,
    parameter logic [paddr_width_p-1:0] dram_base_p    = 40'h00_8000_0000,
    parameter logic [paddr_width_p-1:0] coproc_base_p  = 40'h10_0000_0000,
    parameter int                       tile_lsb_p     = 22,
    parameter int                       host_tile_p    = 'h7F
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    bp_me_addr_to_cce_id_pipe_if.slave    bus,
    input  logic                          cfg_w_v_i,
    input  logic [cfg_addr_width_lp-1:0]  cfg_addr_i,
    input  logic [cfg_data_width_lp-1:0]  cfg_data_i,
    output logic [cfg_data_width_lp-1:0]  cfg_data_o
);

    logic [5:0]                              r_stripe_shift;
    bp_me_cce_region_s [num_region_p-1:0]    r_region;

    logic                      r_v;
    logic [paddr_width_p-1:0]  r_paddr;
    logic [cce_id_width_p-1:0] r_cce_id;
    logic                      r_hit;

    logic                      w_accept;
    logic                      w_hit;
    logic [cce_id_width_p-1:0] w_region_id;
    logic [tile_width_lp-1:0]  w_tile;
    logic                      w_below_dram;
    logic                      w_below_coproc;
    logic                      w_is_io;
    logic [cce_id_width_p-1:0] w_io_id;
    logic [cce_id_width_p-1:0] w_tile_id;
    logic [cce_id_width_p-1:0] w_dram_id;
    logic [cce_id_width_p-1:0] w_class_id;

    // Config writes land at the edge, so a request accepted on the same edge
    // is decoded with the previous contents.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_stripe_shift <= stripe_reset_lp;
            r_region       <= '0;
        end else if (cfg_w_v_i) begin
            if (cfg_addr_i == cfg_stripe_addr_lp)
                r_stripe_shift <= clamp_stripe(cfg_data_i);
            for (int k = 0; k < num_region_p; k++) begin
                if (cfg_addr_i == cfg_region_addr(k, cfg_field_base_lp))
                    r_region[k].base <= cfg_data_i[paddr_width_p-1:0];
                if (cfg_addr_i == cfg_region_addr(k, cfg_field_mask_lp))
                    r_region[k].mask <= cfg_data_i[paddr_width_p-1:0];
                if (cfg_addr_i == cfg_region_addr(k, cfg_field_ctrl_lp)) begin
                    r_region[k].en <= cfg_data_i[cfg_ctrl_en_bit_lp];
                    r_region[k].id <= cfg_data_i[cce_id_width_p-1:0];
                end
            end
        end
    end

    always_comb begin
        cfg_data_o = '0;
        if (cfg_addr_i == cfg_stripe_addr_lp)
            cfg_data_o = cfg_data_width_lp'(r_stripe_shift);
        for (int k = 0; k < num_region_p; k++) begin
            if (cfg_addr_i == cfg_region_addr(k, cfg_field_base_lp))
                cfg_data_o = cfg_data_width_lp'(r_region[k].base);
            if (cfg_addr_i == cfg_region_addr(k, cfg_field_mask_lp))
                cfg_data_o = cfg_data_width_lp'(r_region[k].mask);
            if (cfg_addr_i == cfg_region_addr(k, cfg_field_ctrl_lp)) begin
                cfg_data_o[cfg_ctrl_en_bit_lp]   = r_region[k].en;
                cfg_data_o[cce_id_width_p-1:0]   = r_region[k].id;
            end
        end
    end

    bp_me_cce_region_match #(
        .num_region_p (num_region_p)
    ) u_region_match (
        .i_paddr   (bus.paddr_i),
        .i_regions (r_region),
        .o_hit     (w_hit),
        .o_id      (w_region_id)
    );

    assign w_tile         = bus.paddr_i[tile_lsb_p +: tile_width_lp];
    assign w_below_dram   = bus.paddr_i < dram_base_p;
    assign w_below_coproc = bus.paddr_i < coproc_base_p;
    // Top two address bits above 1 select the I/O space; the host tile code
    // inside the local space also routes to I/O.
    assign w_is_io        = (bus.paddr_i[paddr_width_p-1:paddr_width_p-2] > 2'd1) ||
                            (w_below_dram && (w_tile == tile_width_lp'(host_tile_p)));

    assign w_io_id   = cce_id_width_p'(io_base_p) +
                       cce_id_width_p'((bus.paddr_i >> 12) % paddr_width_p'(num_io_p));
    assign w_tile_id = cce_id_width_p'(w_tile);
    assign w_dram_id = cce_id_width_p'((bus.paddr_i >> r_stripe_shift) &
                                       paddr_width_p'(num_cce_p - 1));

    always_comb begin
        w_class_id = cce_id_width_p'(sacc_base_p);
        if (w_is_io)
            w_class_id = w_io_id;
        else if (w_below_dram)
            w_class_id = w_tile_id;
        else if (w_below_coproc)
            w_class_id = w_dram_id;
    end

    assign bus.ready_o = ~r_v | bus.ready_i;
    assign w_accept    = bus.v_i & bus.ready_o;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_v      <= 1'b0;
            r_paddr  <= '0;
            r_cce_id <= '0;
            r_hit    <= 1'b0;
        end else if (w_accept) begin
            r_v      <= 1'b1;
            r_paddr  <= bus.paddr_i;
            r_cce_id <= w_hit ? w_region_id : w_class_id;
            r_hit    <= w_hit;
        end else if (bus.ready_i) begin
            r_v      <= 1'b0;
        end
    end

    assign bus.v_o          = r_v;
    assign bus.paddr_o      = r_paddr;
    assign bus.cce_id_o     = r_cce_id;
    assign bus.region_hit_o = r_hit;

endmodule
